// File: rtl/jtag_scan_engine.sv
// rtl/jtag_scan_engine.sv - JTAG TAP scan engine with TCK divider, IR/DR scan, RTI and abort
module jtag_scan_engine #(
    parameter int MAXBITS = 64,
    parameter int CNTW    = 7,
    parameter int DIVW    = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [DIVW-1:0]    div,
    input  logic [1:0]         cmd,
    input  logic [CNTW-1:0]    len,
    input  logic [MAXBITS-1:0] din,
    input  logic [7:0]         rti_cycles,
    input  logic               go,
    input  logic               abort,
    output logic               busy,
    output logic               done,
    output logic               aborted,
    output logic [MAXBITS-1:0] dout,
    output logic               tck,
    output logic               tms,
    output logic               tdi,
    input  logic               tdo
);

    // Step counter must cover both scan bits and up to 255 idle TCKs.
    localparam int CW = (CNTW > 8) ? CNTW : 8;
    localparam int IW = $clog2(MAXBITS);
    localparam logic [CNTW-1:0] LEN_MAX = CNTW'(MAXBITS - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_TMSSEQ, S_SHIFT, S_EXIT, S_RTI, S_ABORT, S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [1:0]         cmd_q, cmd_d;
    logic [CW-1:0]      len_q, len_d;
    logic [MAXBITS-1:0] din_q, din_d;
    logic [7:0]         rti_q, rti_d;
    logic [DIVW-1:0]    div_q, div_d;
    logic [DIVW-1:0]    div_cnt_q, div_cnt_d;
    logic               tck_q, tck_d;
    logic               tms_q, tms_d;
    logic               tdi_q, tdi_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [MAXBITS-1:0] dout_q, dout_d;
    logic               aborted_q, aborted_d;
    logic               abort_pend_q, abort_pend_d;

    logic               term, fall_ev, rise_ev;
    logic [CNTW-1:0]    len_c;
    logic [IW-1:0]      idx;
    logic [CW-1:0]      seq_last;
    logic               seq_bit;

    assign busy    = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done    = (state_q == S_DONE);
    assign aborted = aborted_q;
    assign dout    = dout_q;
    assign tck     = tck_q;
    assign tms     = tms_q;
    assign tdi     = tdi_q;

    // TCK divider: toggles at terminal count while busy, parked high otherwise.
    always_comb begin
        term      = (div_cnt_q == div_q);
        fall_ev   = busy && term && tck_q;
        rise_ev   = busy && term && !tck_q;
        div_cnt_d = div_cnt_q;
        tck_d     = tck_q;
        if (busy) begin
            if (term) begin
                div_cnt_d = '0;
                tck_d     = ~tck_q;
            end else begin
                div_cnt_d = div_cnt_q + DIVW'(1);
            end
        end else begin
            div_cnt_d = '0;
            tck_d     = 1'b1;
        end
    end

    // Scan sequencer: drives TMS/TDI on falls, samples TDO and steps on rises.
    always_comb begin
        state_d      = state_q;
        cmd_d        = cmd_q;
        len_d        = len_q;
        din_d        = din_q;
        rti_d        = rti_q;
        div_d        = div_q;
        tms_d        = tms_q;
        tdi_d        = tdi_q;
        cnt_d        = cnt_q;
        dout_d       = dout_q;
        aborted_d    = aborted_q;
        abort_pend_d = abort_pend_q;

        len_c = (len > LEN_MAX) ? LEN_MAX : len;
        idx   = cnt_q[IW-1:0];

        // Preamble lengths: TLR walk 6, to Shift-IR 4, to Shift-DR 3.
        case (cmd_q)
            2'd0:    seq_last = CW'(5);
            2'd1:    seq_last = CW'(3);
            default: seq_last = CW'(2);
        endcase
        case (cmd_q)
            2'd0:    seq_bit = (cnt_q < CW'(5));
            2'd1:    seq_bit = (cnt_q < CW'(2));
            default: seq_bit = (cnt_q < CW'(1));
        endcase

        // Abort is remembered and honoured at the next fall event.
        if (busy && abort && (state_q != S_ABORT)) begin
            abort_pend_d = 1'b1;
        end

        case (state_q)
            S_IDLE, S_DONE: begin
                state_d      = S_IDLE;
                abort_pend_d = 1'b0;
                if (go) begin
                    cmd_d     = cmd;
                    len_d     = CW'(len_c);
                    din_d     = din;
                    rti_d     = rti_cycles;
                    div_d     = div;
                    cnt_d     = '0;
                    aborted_d = 1'b0;
                    for (int i = 0; i < MAXBITS; i++) begin
                        if (i > int'(len_c)) begin
                            dout_d[i] = 1'b0;
                        end
                    end
                    if (cmd != 2'd3) begin
                        state_d = S_TMSSEQ;
                    end else if (rti_cycles == 8'd0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_RTI;
                    end
                end
            end
            default: begin
                if (fall_ev) begin
                    tdi_d = 1'b1;
                    if (abort_pend_q && (state_q != S_ABORT)) begin
                        state_d      = S_ABORT;
                        cnt_d        = '0;
                        tms_d        = 1'b1;
                        abort_pend_d = 1'b0;
                    end else begin
                        case (state_q)
                            S_TMSSEQ: tms_d = seq_bit;
                            S_SHIFT: begin
                                tms_d = (cnt_q == len_q);
                                tdi_d = din_q[idx];
                            end
                            S_EXIT:   tms_d = (cnt_q == '0);
                            S_ABORT:  tms_d = (cnt_q < CW'(5));
                            default:  tms_d = 1'b0;
                        endcase
                    end
                end
                if (rise_ev) begin
                    cnt_d = cnt_q + CW'(1);
                    case (state_q)
                        S_TMSSEQ: begin
                            if (cnt_q == seq_last) begin
                                cnt_d   = '0;
                                state_d = (cmd_q == 2'd0) ? S_DONE : S_SHIFT;
                            end
                        end
                        S_SHIFT: begin
                            dout_d[idx] = tdo;
                            if (cnt_q == len_q) begin
                                cnt_d   = '0;
                                state_d = S_EXIT;
                            end
                        end
                        S_EXIT: begin
                            if (cnt_q == CW'(1)) begin
                                cnt_d   = '0;
                                state_d = (rti_q == 8'd0) ? S_DONE : S_RTI;
                            end
                        end
                        S_RTI: begin
                            if (cnt_q == CW'(rti_q - 8'd1)) begin
                                cnt_d   = '0;
                                state_d = S_DONE;
                            end
                        end
                        default: begin
                            if (cnt_q == CW'(5)) begin
                                cnt_d     = '0;
                                state_d   = S_DONE;
                                aborted_d = 1'b1;
                            end
                        end
                    endcase
                end
            end
        endcase
    end

    // State and datapath registers with asynchronous reset to the parked TAP levels.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            cmd_q        <= '0;
            len_q        <= '0;
            din_q        <= '0;
            rti_q        <= '0;
            div_q        <= '0;
            div_cnt_q    <= '0;
            tck_q        <= 1'b1;
            tms_q        <= 1'b1;
            tdi_q        <= 1'b1;
            cnt_q        <= '0;
            dout_q       <= '0;
            aborted_q    <= 1'b0;
            abort_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cmd_q        <= cmd_d;
            len_q        <= len_d;
            din_q        <= din_d;
            rti_q        <= rti_d;
            div_q        <= div_d;
            div_cnt_q    <= div_cnt_d;
            tck_q        <= tck_d;
            tms_q        <= tms_d;
            tdi_q        <= tdi_d;
            cnt_q        <= cnt_d;
            dout_q       <= dout_d;
            aborted_q    <= aborted_d;
            abort_pend_q <= abort_pend_d;
        end
    end

endmodule

// File: tb/tb_jtag_scan_engine.sv
// tb/tb_jtag_scan_engine.sv - randomized self-checking bench for jtag_scan_engine
module tb_jtag_scan_engine;

    localparam int MAXBITS = 64;
    localparam int CNTW    = 7;
    localparam int DIVW    = 8;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic [DIVW-1:0]    div = '0;
    logic [1:0]         cmd = '0;
    logic [CNTW-1:0]    len = '0;
    logic [MAXBITS-1:0] din = '0;
    logic [7:0]         rti_cycles = '0;
    logic               go = 1'b0;
    logic               abort = 1'b0;
    logic               busy, done, aborted, tck, tms, tdi;
    logic [MAXBITS-1:0] dout;
    logic               tdo = 1'b0;

    jtag_scan_engine #(.MAXBITS(MAXBITS), .CNTW(CNTW), .DIVW(DIVW)) dut (
        .clk(clk), .rst_n(rst_n), .div(div), .cmd(cmd), .len(len), .din(din),
        .rti_cycles(rti_cycles), .go(go), .abort(abort), .busy(busy), .done(done),
        .aborted(aborted), .dout(dout), .tck(tck), .tms(tms), .tdi(tdi), .tdo(tdo)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic [63:0] dmodel = '0;
    bit exp_tms[$];
    bit exp_tdi[$];
    bit got_tms[$];
    bit got_tdi[$];
    bit got_tdo[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int tck_total(input int c, input int l, input int r);
        int lc;
        lc = (l > MAXBITS - 1) ? MAXBITS - 1 : l;
        case (c)
            0:       return 6;
            1:       return 4 + lc + 1 + 2 + r;
            2:       return 3 + lc + 1 + 2 + r;
            default: return r;
        endcase
    endfunction

    // tdo_mode: 0 random, 1 looped from tdi, 2 held high
    task automatic run_op(input int c, input int l, input logic [63:0] d, input int r,
                          input int dv, input int tdo_mode, input int abort_at,
                          input int gob_at, input bit abort_with_go, input string name);
        int lenc, pre, nfull, nexp, k, errs;
        bit ab_eff, prev;
        lenc = (l > MAXBITS - 1) ? MAXBITS - 1 : l;
        pre = (c == 1) ? 4 : (c == 2) ? 3 : 0;
        exp_tms.delete(); exp_tdi.delete();
        got_tms.delete(); got_tdi.delete(); got_tdo.delete();
        if (c == 0) begin
            for (int i = 0; i < 6; i++) begin
                exp_tms.push_back(i < 5); exp_tdi.push_back(1'b1);
            end
        end else begin
            for (int i = 0; i < pre; i++) begin
                exp_tms.push_back(i < pre - 2); exp_tdi.push_back(1'b1);
            end
            if (c != 3) begin
                for (int i = 0; i <= lenc; i++) begin
                    exp_tms.push_back(i == lenc); exp_tdi.push_back(d[i]);
                end
                exp_tms.push_back(1'b1); exp_tdi.push_back(1'b1);
                exp_tms.push_back(1'b0); exp_tdi.push_back(1'b1);
            end
            for (int i = 0; i < r; i++) begin
                exp_tms.push_back(1'b0); exp_tdi.push_back(1'b1);
            end
        end
        nfull = exp_tms.size();
        ab_eff = (abort_at > 0) && (abort_at < nfull);
        if (ab_eff) begin
            while (exp_tms.size() > abort_at) begin
                void'(exp_tms.pop_back()); void'(exp_tdi.pop_back());
            end
            for (int i = 0; i < 6; i++) begin
                exp_tms.push_back(i < 5); exp_tdi.push_back(1'b1);
            end
        end
        nexp = exp_tms.size();
        for (int i = lenc + 1; i < MAXBITS; i++) dmodel[i] = 1'b0;

        cmd = 2'(c); len = CNTW'(l); din = d; rti_cycles = 8'(r); div = DIVW'(dv);
        go = 1'b1; abort = abort_with_go;
        @(posedge clk);
        k = 0; prev = 1'b1;
        @(negedge clk);
        check({name, "_busy_start"}, busy, nfull > 0);
        forever begin
            go = 1'b0; abort = 1'b0;
            if (tck && !prev) begin
                got_tms.push_back(tms); got_tdi.push_back(tdi); got_tdo.push_back(tdo);
                if (got_tms.size() == abort_at) abort = 1'b1;
                if (got_tms.size() == gob_at) begin
                    go = 1'b1; cmd = ~cmd; din = ~d; len = CNTW'(l ^ 5);
                end
            end
            if (!tck && prev) begin
                tdo = (tdo_mode == 0) ? 1'($urandom % 2) : (tdo_mode == 1) ? tdi : 1'b1;
            end
            prev = tck;
            if (done) break;
            if (k > 20000) begin
                check({name, "_timeout"}, k, 0);
                break;
            end
            @(posedge clk); k++;
            @(negedge clk);
        end
        check({name, "_cycles"}, k, 2 * nexp * (dv + 1));
        check({name, "_busy_done"}, busy, 0);
        check({name, "_aborted"}, aborted, ab_eff);
        check({name, "_ntck"}, got_tms.size(), nexp);
        errs = 0;
        for (int i = 0; i < nexp && i < got_tms.size(); i++) begin
            if (got_tms[i] != exp_tms[i]) errs++;
            if (got_tdi[i] != exp_tdi[i]) errs++;
        end
        check({name, "_seq_errs"}, errs, 0);
        if (c == 1 || c == 2) begin
            for (int i = 0; i <= lenc; i++) begin
                if ((pre + i < got_tdo.size()) && (!ab_eff || pre + i < abort_at))
                    dmodel[i] = got_tdo[pre + i];
            end
        end
        check({name, "_dout"}, dout, dmodel);
        @(posedge clk);
        @(negedge clk);
        abort = 1'b0; go = 1'b0;
        check({name, "_done_width"}, done, 0);
        check({name, "_aborted_hold"}, aborted, ab_eff);
        check({name, "_dout_hold"}, dout, dmodel);
    endtask

    initial begin
        int c, l, r, dv, nf, ab_at, gb_at;
        logic [63:0] d;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_tck", tck, 1);
        check("rst_tms", tms, 1);
        check("rst_tdi", tdi, 1);
        check("rst_done", done, 0);
        check("rst_dout", dout, 0);
        rst_n = 1'b1;

        run_op(2, 31, 64'hA5A5F00F, 0, 0, 1, 0, 0, 0, "dr32");
        check("dr32_value", dout, 64'hA5A5F00F);
        check("dr32_tcks", got_tms.size(), 37);
        run_op(1, 3, 64'hE, 0, 0, 2, 0, 0, 0, "ir4");
        check("ir4_value", dout, 64'hF);
        run_op(0, 3, 64'h0, 0, 3, 0, 0, 0, 0, "tlr");
        run_op(2, 63, {$urandom, $urandom}, 0, 1, 0, 14, 0, 0, "abort64");
        run_op(2, 15, {$urandom, $urandom}, 2, 0, 0, 0, 5, 0, "go_busy");
        run_op(1, 7, {$urandom, $urandom}, 1, 0, 0, 0, 0, 1, "go_abort");
        run_op(3, 0, 64'h0, 0, 0, 0, 0, 0, 0, "idle0");
        run_op(3, 0, 64'h0, 5, 1, 0, 0, 0, 0, "idle5");
        run_op(2, 100, {$urandom, $urandom}, 0, 0, 1, 0, 0, 0, "clamp");

        cmd = 2'd2; len = 7'd63; din = {$urandom, $urandom}; div = '0; rti_cycles = '0;
        go = 1'b1;
        @(posedge clk);
        @(negedge clk);
        go = 1'b0;
        repeat (20) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_tck", tck, 1);
        check("midrst_tms", tms, 1);
        check("midrst_busy", busy, 0);
        check("midrst_dout", dout, 0);
        check("midrst_aborted", aborted, 0);
        @(negedge clk);
        rst_n = 1'b1;
        dmodel = '0;
        run_op(1, 5, {$urandom, $urandom}, 1, 0, 0, 0, 0, 0, "after_rst");

        for (int n = 0; n < 24; n++) begin
            c = $urandom % 4;
            l = ($urandom % 8 == 0) ? 64 + $urandom % 64 : $urandom % 64;
            d = {$urandom, $urandom};
            r = $urandom % 4;
            dv = $urandom % 4;
            nf = tck_total(c, l, r);
            ab_at = 0; gb_at = 0;
            if ($urandom % 4 == 0 && nf > 0) begin
                ab_at = 1 + $urandom % nf;
                dv = 1 + $urandom % 3;
            end else if ($urandom % 4 == 0 && nf > 1) begin
                gb_at = 1 + $urandom % (nf - 1);
            end
            run_op(c, l, d, r, dv, $urandom % 2, ab_at, gb_at, ($urandom % 5) == 0, "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
